gascon_perm_engine: RTL and testbench
=====================================

# gascon_perm_engine

Iterative, parametrised GASCON permutation engine. It generalises the single-round datapath to N 64-bit state words, a programmable round count and 1..4 rounds unrolled per cycle. A start/done handshake wraps the datapath. It sits between the mode controller (absorb/squeeze FSM) and the state register file, and replaces the free-running single-round core.

## Interface
- CWORDS64, default 5: state words; legal 5 or 7; CWIDTH = 64*CWORDS64.
- ROUND_COUNT, default 12: maximum rounds per call; legal 1..16.
- UNROLL, default 1: rounds evaluated per clock; legal 1, 2, 3, 4.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only when ready=1.
- num_rounds  in  5  rounds for this call; sampled with start.
- c  in  CWIDTH  input state; sampled with start.
- ready  out  1  engine idle, start accepted.
- cout  out  CWIDTH  result state; valid from done until next accepted start.
- done  out  1  one-cycle pulse on completion.

## Operation
- FSM states IDLE, RUN, FIN.
- IDLE: ready=1. start=1 loads c into the state register and sets r = ROUND_COUNT - n, where n = min(num_rounds, ROUND_COUNT). It then goes to RUN, or to FIN when n=0.
- RUN: each cycle applies k = min(UNROLL, ROUND_COUNT - r) rounds, then r += k. When r reaches ROUND_COUNT the FSM goes to FIN.
- FIN: done=1 for one cycle, cout = state, then return to IDLE.
- Round i (index r): the round constant is (((0xF - r) << 4) | r), zero-extended to 64 bits. It is XORed into word MID = (CWORDS64-1)/2.
- S-box layer: x[2d] ^= x[2d-1 mod N] for even indices. Then chi: x[j] ^= ~x[j+1] & x[j+2], indices mod N, all reading pre-chi values. Then x[2d+1] ^= x[2d] and x[MID] = ~x[MID].
- Linear layer: x[j] ^= rotr(x[j], R0[j]) ^ rotr(x[j], R1[j]).
- Rotation table: (19,28), (61,39), (1,6), (10,17), (7,41), (13,46), (53,58).
- start while not ready is ignored; it is not queued.
- Inputs c and num_rounds are not required to be held after acceptance.

## Timing
- Reset (reset=0 at a clock edge) forces: state IDLE, ready=1, done=0, cout=0, round counter 0, from the next cycle.
- Reset mid-RUN discards the computation; no done pulse.
- Start accepted at edge T. Completion takes K = ceil(n/UNROLL) RUN cycles; done is high in cycle T+K+1.
- n=0: done is high in cycle T+1 and cout=c (zero-latency bypass excluded).
- The next start is accepted in the cycle after done; back-to-back throughput is K+2 cycles per call.
- The last RUN cycle may apply fewer than UNROLL rounds; unused unrolled stages are bypassed.
- num_rounds > ROUND_COUNT is clamped to ROUND_COUNT, with no error.
- done and start coincident: start is ignored (ready=0 in FIN).

## Configuration
- GASCON_ABORT_EN defined: adds input abort (1 bit). abort=1 in RUN or FIN returns the FSM to IDLE next cycle. No done pulse; cout keeps its previous value. Abort has priority over completion in the same cycle.
- GASCON_ABORT_EN not defined: no abort port; every accepted call runs to completion.

## Structure
- gascon_pkg holds:
  - the state typedef (array of CWORDS64 64-bit words);
  - the FSM state enum;
  - the rotation constant table;
  - function rc(r) returning the round constant;
  - the legal-parameter checks.
- One sub-module, gascon_round_comb: purely combinational single round, with inputs state and round index and output next state. The engine instantiates UNROLL copies in a chain, each with a bypass mux.

## Test plan
- c=0, num_rounds=12, UNROLL=1, CWORDS64=5 -> done exactly 13 cycles after the start edge; cout equals the golden model's 12-round output.
- Same input with UNROLL=4 -> done after 4 cycles (K=3); cout is bit-identical to the UNROLL=1 result.
- num_rounds=0, c=0x0123...EF pattern -> done at T+1; cout=c.
- num_rounds=7, UNROLL=3 -> K=3 (3+3+1 rounds), rounds 5..11 applied; first constant 0xA5, last 0x4B.
- reset low during RUN cycle 2, then start with new c -> no done for the first call; second result is correct.
- GASCON_ABORT_EN: abort in RUN -> ready=1 next cycle, no done; a fresh 12-round call then completes normally; num_rounds=20 behaves as 12.

Source files
------------

// File: rtl/gascon_pkg.sv
// rtl/gascon_pkg.sv - shared types, constants and helpers for the GASCON permutation engine
package gascon_pkg;

    typedef logic [63:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN
    } fsm_e;

    localparam int unsigned ROT_R0 [7] = '{19, 61,  1, 10,  7, 13, 53};
    localparam int unsigned ROT_R1 [7] = '{28, 39,  6, 17, 41, 46, 58};

    function automatic word_t rc(input logic [3:0] r);
        return {56'd0, 4'hF - r, r};
    endfunction

    function automatic word_t rotr(input word_t v, input int unsigned s);
        return (v >> s) | (v << (64 - s));
    endfunction

    function automatic bit params_ok(input int words, input int rounds, input int unroll);
        return ((words == 5) || (words == 7)) &&
               (rounds >= 1) && (rounds <= 16) &&
               (unroll >= 1) && (unroll <= 4);
    endfunction

endpackage

// File: rtl/gascon_round_comb.sv
// rtl/gascon_round_comb.sv - one combinational GASCON round over CWORDS64 64-bit words
module gascon_round_comb
    import gascon_pkg::*;
#(
    parameter int CWORDS64 = 5
) (
    input  word_t [CWORDS64-1:0] state_i,
    input  logic  [3:0]          round_i,
    output word_t [CWORDS64-1:0] state_o
);

    localparam int N   = CWORDS64;
    localparam int MID = (N - 1) / 2;

    word_t [N-1:0] a;
    word_t [N-1:0] b;
    word_t [N-1:0] d;
    word_t [N-1:0] e;

    always_comb begin
        a      = state_i;
        a[MID] = state_i[MID] ^ rc(round_i);

        // Odd N means word N-1 is even; word 0 must still see its pre-update value.
        b = a;
        for (int j = 0; j < N; j += 2) begin
            b[j] = a[j] ^ a[(j + N - 1) % N];
        end

        d = '0;
        for (int j = 0; j < N; j++) begin
            d[j] = b[j] ^ (~b[(j + 1) % N] & b[(j + 2) % N]);
        end

        e = d;
        for (int j = 1; j < N; j += 2) begin
            e[j] = d[j] ^ d[j - 1];
        end
        e[MID] = ~e[MID];

        state_o = '0;
        for (int j = 0; j < N; j++) begin
            state_o[j] = e[j] ^ rotr(e[j], ROT_R0[j]) ^ rotr(e[j], ROT_R1[j]);
        end
    end

endmodule

// File: rtl/gascon_perm_engine.sv
// rtl/gascon_perm_engine.sv - iterative GASCON permutation with start/done handshake; GASCON_ABORT_EN adds abort
module gascon_perm_engine
    import gascon_pkg::*;
#(
    parameter  int CWORDS64    = 5,
    parameter  int ROUND_COUNT = 12,
    parameter  int UNROLL      = 1,
    localparam int CWIDTH      = 64 * CWORDS64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        num_rounds,
    input  logic [CWIDTH-1:0] c,
`ifdef GASCON_ABORT_EN
    input  logic              abort,
`endif
    output logic              ready,
    output logic [CWIDTH-1:0] cout,
    output logic              done
);

    typedef word_t [CWORDS64-1:0] state_t;

    localparam logic [4:0] RC5 = 5'(ROUND_COUNT);

    if (!params_ok(CWORDS64, ROUND_COUNT, UNROLL)) begin : g_param_check
        $error("gascon_perm_engine: illegal parameter set");
    end

    fsm_e       fsm_q, fsm_d;
    state_t     state_q, state_d;
    state_t     cout_q, cout_d;
    logic [4:0] rnd_q, rnd_d;
    logic       abort_w;
    logic [4:0] n_clamp;
    logic       last_step;

`ifdef GASCON_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    state_t     chain     [UNROLL+1];
    state_t     stage_out [UNROLL];
    logic [4:0] stage_idx [UNROLL];

    assign chain[0] = state_q;

    // Stages past the last remaining round pass the state through untouched.
    for (genvar g = 0; g < UNROLL; g++) begin : g_stage
        assign stage_idx[g] = rnd_q + 5'(g);
        gascon_round_comb #(.CWORDS64(CWORDS64)) u_round (
            .state_i (chain[g]),
            .round_i (stage_idx[g][3:0]),
            .state_o (stage_out[g])
        );
        assign chain[g+1] = (stage_idx[g] < RC5) ? stage_out[g] : chain[g];
    end

    assign n_clamp   = (num_rounds > RC5) ? RC5 : num_rounds;
    assign last_step = ({1'b0, rnd_q} + 6'(UNROLL)) >= {1'b0, RC5};

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        cout_d  = cout_q;
        rnd_d   = rnd_q;
        ready   = 1'b0;
        done    = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_d = c;
                    rnd_d   = RC5 - n_clamp;
                    fsm_d   = (n_clamp == 5'd0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_w) begin
                    fsm_d = ST_IDLE;
                end else begin
                    state_d = chain[UNROLL];
                    if (last_step) begin
                        rnd_d = RC5;
                        fsm_d = ST_FIN;
                    end else begin
                        rnd_d = rnd_q + 5'(UNROLL);
                    end
                end
            end
            ST_FIN: begin
                fsm_d = ST_IDLE;
                if (!abort_w) begin
                    done   = 1'b1;
                    cout_d = state_q;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            cout_q  <= '0;
            rnd_q   <= 5'd0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cout_q  <= cout_d;
            rnd_q   <= rnd_d;
        end
    end

    // The result is visible during the done cycle, then held until the next call completes.
    assign cout = (fsm_q == ST_FIN) ? state_q : cout_q;

endmodule

// File: tb/tb_gascon_perm_engine.sv
// tb/tb_gascon_perm_engine.sv - directed self-checking bench for gascon_perm_engine
module tb_gascon_perm_engine;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [4:0]   num_rounds;
    logic [319:0] c;
    logic [447:0] c7;
`ifdef GASCON_ABORT_EN
    logic         abort;
`endif
    logic [3:0]   ready_v;
    logic [3:0]   done_v;
    logic [319:0] cout1, cout3, cout4;
    logic [447:0] cout7;

    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           t0;
    int           n_done  [4] = '{0, 0, 0, 0};
    int           at_done [4] = '{0, 0, 0, 0};
    int           base    [4];
    logic [447:0] cap     [4];
    logic [447:0] prev1;

    localparam logic [319:0] PAT5  = {5{64'h0123456789ABCDEF}};
    localparam logic [447:0] PAT7  = {7{64'h0123456789ABCDEF}};
    localparam logic [319:0] PAT5B = {5{64'hFEDCBA9876543210}} ^ {64'h1, 64'h2, 64'h4, 64'h8, 64'h10};
    localparam logic [447:0] PAT7B = {7{64'h5A5AC3C30F0F9696}};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gascon_perm_engine #(.CWORDS64(5), .ROUND_COUNT(12), .UNROLL(1)) u1 (
        .clk(clk), .reset(reset), .start(start), .num_rounds(num_rounds), .c(c),
`ifdef GASCON_ABORT_EN
        .abort(abort),
`endif
        .ready(ready_v[0]), .cout(cout1), .done(done_v[0]));
    gascon_perm_engine #(.CWORDS64(5), .ROUND_COUNT(12), .UNROLL(3)) u3 (
        .clk(clk), .reset(reset), .start(start), .num_rounds(num_rounds), .c(c),
`ifdef GASCON_ABORT_EN
        .abort(abort),
`endif
        .ready(ready_v[1]), .cout(cout3), .done(done_v[1]));
    gascon_perm_engine #(.CWORDS64(5), .ROUND_COUNT(12), .UNROLL(4)) u4 (
        .clk(clk), .reset(reset), .start(start), .num_rounds(num_rounds), .c(c),
`ifdef GASCON_ABORT_EN
        .abort(abort),
`endif
        .ready(ready_v[2]), .cout(cout4), .done(done_v[2]));
    gascon_perm_engine #(.CWORDS64(7), .ROUND_COUNT(12), .UNROLL(2)) u7 (
        .clk(clk), .reset(reset), .start(start), .num_rounds(num_rounds), .c(c7),
`ifdef GASCON_ABORT_EN
        .abort(abort),
`endif
        .ready(ready_v[3]), .cout(cout7), .done(done_v[3]));

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done_v[i]) begin
                n_done[i]++;
                at_done[i] = cyc;
            end
        end
        if (done_v[0]) cap[0] = {128'd0, cout1};
        if (done_v[1]) cap[1] = {128'd0, cout3};
        if (done_v[2]) cap[2] = {128'd0, cout4};
        if (done_v[3]) cap[3] = cout7;
    end

    // Reference-style round loop: sequential updates, chi via temporaries.
    function automatic logic [447:0] gmodel(input logic [447:0] v, input int n, input int r0, input int cnt);
        logic [63:0]  x [7];
        logic [63:0]  t [7];
        logic [447:0] res;
        int           ra [7] = '{19, 61, 1, 10, 7, 13, 53};
        int           rb [7] = '{28, 39, 6, 17, 41, 46, 58};
        int           mid;
        mid = (n - 1) / 2;
        for (int i = 0; i < 7; i++) x[i] = (i < n) ? v[64*i +: 64] : 64'd0;
        for (int r = r0; r < r0 + cnt; r++) begin
            x[mid] ^= 64'((15 - r) * 16 + r);
            for (int i = 0; i < n; i += 2) x[i] ^= x[(i + n - 1) % n];
            for (int i = 0; i < n; i++) t[i] = ~x[i] & x[(i + 1) % n];
            for (int i = 0; i < n; i++) x[i] ^= t[(i + 1) % n];
            for (int i = 1; i < n; i += 2) x[i] ^= x[i - 1];
            x[mid] = ~x[mid];
            for (int i = 0; i < n; i++)
                x[i] = x[i] ^ ((x[i] >> ra[i]) | (x[i] << (64 - ra[i])))
                            ^ ((x[i] >> rb[i]) | (x[i] << (64 - rb[i])));
        end
        res = '0;
        for (int i = 0; i < n; i++) res[64*i +: 64] = x[i];
        return res;
    endfunction

    task automatic check(input string tag, input logic [447:0] obs, input logic [447:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [319:0] cv, input logic [447:0] cv7, input logic [4:0] nr);
        c          = cv;
        c7         = cv7;
        num_rounds = nr;
        start      = 1'b1;
        step(1);
        start      = 1'b0;
        c          = ~cv;
        c7         = ~cv7;
        num_rounds = 5'd3;
        t0         = cyc;
        for (int i = 0; i < 4; i++) base[i] = n_done[i];
    endtask

    task automatic verify(input string tag, input logic [319:0] cv, input logic [447:0] cv7, input int nr);
        int           n;
        int           k   [4];
        logic [447:0] exp_v [4];
        n        = (nr > 12) ? 12 : nr;
        k[0]     = n;
        k[1]     = (n + 2) / 3;
        k[2]     = (n + 3) / 4;
        k[3]     = (n + 1) / 2;
        exp_v[0] = gmodel({128'd0, cv}, 5, 12 - n, n);
        exp_v[1] = exp_v[0];
        exp_v[2] = exp_v[0];
        exp_v[3] = gmodel(cv7, 7, 12 - n, n);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s done_count[%0d]", tag, i), 448'(n_done[i] - base[i]), 448'(1));
            check($sformatf("%s latency[%0d]", tag, i), 448'(at_done[i] - t0 + 1), 448'(k[i] + 1));
            check($sformatf("%s cout_at_done[%0d]", tag, i), cap[i], exp_v[i]);
        end
        check($sformatf("%s cout_held", tag), {128'd0, cout1}, exp_v[0]);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        num_rounds = 5'd0;
        c          = '0;
        c7         = '0;
`ifdef GASCON_ABORT_EN
        abort      = 1'b0;
`endif
        step(2);
        check("reset ready", {444'd0, ready_v}, {444'd0, 4'hF});
        check("reset done", {444'd0, done_v}, 448'd0);
        check("reset cout1", {128'd0, cout1}, 448'd0);
        check("reset cout7", cout7, 448'd0);
        reset = 1'b1;
        step(1);

        check("rc(5)", {384'd0, gascon_pkg::rc(4'd5)}, 448'hA5);
        check("rc(11)", {384'd0, gascon_pkg::rc(4'd11)}, 448'h4B);

        // c=0, 12 rounds, with cycle-exact handshake on the single-round instance.
        launch('0, '0, 5'd12);
        step(11);
        check("A pre-done", {446'd0, done_v[0], ready_v[0]}, 448'd0);
        step(1);
        check("A done cycle", {446'd0, done_v[0], ready_v[0]}, 448'b10);
        step(1);
        check("A after done", {446'd0, done_v[0], ready_v[0]}, 448'b01);
        step(10);
        verify("A", '0, '0, 12);
        check("A unroll4 vs unroll1", cap[2], cap[0]);

        launch(PAT5, PAT7, 5'd0);
        step(20);
        verify("B", PAT5, PAT7, 0);

        launch(PAT5, PAT7, 5'd7);
        step(20);
        verify("C", PAT5, PAT7, 7);

        // Clamped call; a start arriving while busy (u4 in its done cycle) must be dropped.
        launch(PAT5B, PAT7B, 5'd20);
        step(3);
        start      = 1'b1;
        c          = PAT5;
        c7         = PAT7;
        num_rounds = 5'd0;
        step(1);
        start      = 1'b0;
        step(19);
        verify("D", PAT5B, PAT7B, 20);

        // Reset during the second RUN cycle discards the call.
        launch(PAT5, PAT7, 5'd12);
        step(1);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        step(20);
        for (int i = 0; i < 4; i++)
            check($sformatf("E no done[%0d]", i), 448'(n_done[i] - base[i]), 448'd0);
        check("E ready", {444'd0, ready_v}, {444'd0, 4'hF});
        check("E cout cleared", {128'd0, cout1}, 448'd0);
        launch(PAT5B, PAT7B, 5'd12);
        step(20);
        verify("F", PAT5B, PAT7B, 12);

`ifdef GASCON_ABORT_EN
        prev1 = {128'd0, cout1};
        launch(PAT5, PAT7, 5'd12);
        step(2);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        check("G ready after abort", {444'd0, ready_v}, {444'd0, 4'hF});
        step(20);
        for (int i = 0; i < 4; i++)
            check($sformatf("G no done[%0d]", i), 448'(n_done[i] - base[i]), 448'd0);
        check("G cout kept", {128'd0, cout1}, prev1);
        launch(PAT5, PAT7, 5'd12);
        step(20);
        verify("H", PAT5, PAT7, 12);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
